// File: rtl/sigm_cordic.sv
// sigm_cordic: sigmoid evaluator built on a pipelined hyperbolic CORDIC
// (rotation mode). Produces cosh, sinh, e^x, 1 + e^-x and sigmoid(x) with
// one sample accepted per clock and a fixed 20-clock latency.
module sigm_cordic #(
    parameter int WIDTH = 16,
    parameter int ITER  = 17
) (
    input  logic                    clk,
    output logic signed [WIDTH-1:0] cosh,
    output logic signed [WIDTH-1:0] sinh,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [31:0]      theta,
    output logic        [WIDTH-1:0] exp,
    output logic        [WIDTH-1:0] denom,
    output logic signed [16:0]      sigmoid,
    input  logic                    rst_n
);

    // Datapath carries two extra sign bits of headroom and two guard bits.
    localparam int DW = WIDTH + 4;

    localparam logic signed [DW-1:0] SMAX = DW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [DW-1:0] SMIN = DW'(-(2 ** (WIDTH - 1)));
    localparam logic signed [DW-1:0] UMAX = DW'((2 ** WIDTH) - 1);
    localparam logic signed [DW-1:0] BIAS = DW'(16000);

    // Shift schedule 1..15 with shifts 4 and 13 issued twice.
    function automatic int unsigned shift_of(input int unsigned k);
        int unsigned s;
        s = k + 1;
        if (k >= 4) s = s - 1;
        if (k >= 14) s = s - 1;
        return s;
    endfunction

    // atanh(2^-i) scaled by 2^30, rounded.
    function automatic logic signed [31:0] atanh_of(input int unsigned i);
        case (i)
            1:       return 32'sh2327D4F5;
            2:       return 32'sd274247419;
            3:       return 32'sd134923406;
            4:       return 32'sd67196451;
            5:       return 32'sd33565361;
            6:       return 32'sd16778582;
            7:       return 32'sd8388779;
            8:       return 32'sd4194325;
            9:       return 32'sd2097155;
            10:      return 32'sd1048576;
            11:      return 32'sd524288;
            12:      return 32'sd262144;
            13:      return 32'sd131072;
            14:      return 32'sd65536;
            15:      return 32'sd32768;
            default: return 32'sd0;
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_s(input logic signed [DW-1:0] v);
        if (v > SMAX) return SMAX[WIDTH-1:0];
        else if (v < SMIN) return SMIN[WIDTH-1:0];
        else return v[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_u(input logic signed [DW-1:0] v);
        if (v < 0) return '0;
        else if (v > UMAX) return '1;
        else return v[WIDTH-1:0];
    endfunction

    logic signed [DW-1:0]    xs [ITER+1];
    logic signed [DW-1:0]    ys [ITER+1];
    logic signed [DW-1:0]    xn [ITER];
    logic signed [DW-1:0]    yn [ITER];
    // The residual angle after the last stage is never needed, so z stops one stage early.
    logic signed [31:0]      zs [ITER];
    logic signed [31:0]      zn [ITER-1];

    logic signed [WIDTH-1:0] cs, sn;
    logic signed [DW-1:0]    esum, dsum;

    logic signed [WIDTH-1:0] cosh_p, sinh_p;
    logic        [WIDTH-1:0] exp_p, denom_p;

    logic        [31:0]      quot;
    logic signed [16:0]      sig_c;

    // Micro-rotations on x/y: direction follows the sign of the residual angle.
    always_comb begin
        for (int unsigned k = 0; k < ITER; k++) begin
            if (zs[k][31]) begin
                xn[k] = xs[k] - (ys[k] >>> shift_of(k));
                yn[k] = ys[k] - (xs[k] >>> shift_of(k));
            end else begin
                xn[k] = xs[k] + (ys[k] >>> shift_of(k));
                yn[k] = ys[k] + (xs[k] >>> shift_of(k));
            end
        end
    end

    // Residual angle update for every stage that feeds a later stage.
    always_comb begin
        for (int unsigned k = 0; k + 1 < ITER; k++) begin
            if (zs[k][31]) zn[k] = zs[k] + atanh_of(shift_of(k));
            else           zn[k] = zs[k] - atanh_of(shift_of(k));
        end
    end

    // Drop guard bits, saturate, and form the e^x and denominator sums.
    always_comb begin
        cs   = sat_s(xs[ITER] >>> 2);
        sn   = sat_s(ys[ITER] >>> 2);
        esum = DW'(cs) + DW'(sn);
        dsum = BIAS + DW'(cs) - DW'(sn);
    end

    // Sigmoid quotient; zero denominator yields zero, overflow clamps positive.
    always_comb begin
        quot  = '0;
        sig_c = '0;
        if (denom_p != '0) begin
            quot = 32'd16000000 / 32'(denom_p);
            if (quot > 32'd65535) sig_c = 17'sd65535;
            else                  sig_c = quot[16:0];
        end
    end

    // Input register and CORDIC stage registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < ITER + 1; k++) begin
                xs[k] <= '0;
                ys[k] <= '0;
            end
            for (int unsigned k = 0; k < ITER; k++) zs[k] <= '0;
        end else begin
            xs[0] <= {{2{x_in[WIDTH-1]}}, x_in, 2'b00};
            ys[0] <= {{2{y_in[WIDTH-1]}}, y_in, 2'b00};
            zs[0] <= theta;
            for (int unsigned k = 0; k < ITER; k++) begin
                xs[k+1] <= xn[k];
                ys[k+1] <= yn[k];
            end
            for (int unsigned k = 0; k + 1 < ITER; k++) zs[k+1] <= zn[k];
        end
    end

    // Post stage and divide/output stage registers, kept aligned per sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cosh_p  <= '0;
            sinh_p  <= '0;
            exp_p   <= '0;
            denom_p <= '0;
            cosh    <= '0;
            sinh    <= '0;
            exp     <= '0;
            denom   <= '0;
            sigmoid <= '0;
        end else begin
            cosh_p  <= cs;
            sinh_p  <= sn;
            exp_p   <= sat_u(esum);
            denom_p <= sat_u(dsum);
            cosh    <= cosh_p;
            sinh    <= sinh_p;
            exp     <= exp_p;
            denom   <= denom_p;
            sigmoid <= sig_c;
        end
    end

endmodule

// File: tb/tb_sigm_cordic.sv
// tb_sigm_cordic: directed checks of sigm_cordic values, latency, streaming and reset.
module tb_sigm_cordic;

    logic               clk;
    logic               rst_n;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic signed [31:0] theta;
    logic signed [15:0] cosh;
    logic signed [15:0] sinh;
    logic        [15:0] exp;
    logic        [15:0] denom;
    logic signed [16:0] sigmoid;

    int errors = 0;
    int checks = 0;

    localparam logic signed [31:0] TH_P03  = 32'h13333333;
    localparam logic signed [31:0] TH_M04  = 32'hE6666666;
    localparam logic signed [31:0] TH_P07  = 32'h2CCCCCCD;
    localparam logic signed [31:0] TH_P01  = 32'h06666666;
    localparam logic signed [31:0] TH_M07  = 32'hD3333333;
    localparam logic signed [31:0] TH_P549 = 32'd589484261;

    sigm_cordic #(.WIDTH(16), .ITER(17)) dut (
        .clk     (clk),
        .cosh    (cosh),
        .sinh    (sinh),
        .x_in    (x_in),
        .y_in    (y_in),
        .theta   (theta),
        .exp     (exp),
        .denom   (denom),
        .sigmoid (sigmoid),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 0.5 % of the nominal value, with a small absolute floor for values near zero.
    function automatic int pct(input int e);
        int t;
        t = (e < 0 ? -e : e) / 200;
        return (t < 8) ? 8 : t;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv, input int tol);
        int  diff;
        logic ok;
        checks++;
        diff = obs - expv;
        if (diff < 0) diff = -diff;
        ok = (diff <= tol);
        assert (ok === 1'b1)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, expv, tol);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cosh"},    int'(cosh),    0, 0);
        chk({tag, "_sinh"},    int'(sinh),    0, 0);
        chk({tag, "_exp"},     int'(exp),     0, 0);
        chk({tag, "_denom"},   int'(denom),   0, 0);
        chk({tag, "_sigmoid"}, int'(sigmoid), 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        x_in  = '0;
        y_in  = '0;
        theta = '0;
        step(2);
        chk_all_zero("reset");

        // Zero input out of reset.
        rst_n = 1'b1;
        step(20);
        chk("zero_cosh",    int'(cosh),    0,     0);
        chk("zero_sinh",    int'(sinh),    0,     0);
        chk("zero_exp",     int'(exp),     0,     0);
        chk("zero_denom",   int'(denom),   16000, 0);
        chk("zero_sigmoid", int'(sigmoid), 1000,  0);

        // theta = 0.3, with exact latency check.
        x_in  = 16'sd19280;
        theta = TH_P03;
        step(19);
        chk("p03_early_cosh", int'(cosh), 0, 0);
        step(1);
        chk("p03_cosh",    int'(cosh),    16691, pct(16691));
        chk("p03_sinh",    int'(sinh),    4862,  pct(4862));
        chk("p03_exp",     int'(exp),     21553, pct(21553));
        chk("p03_denom",   int'(denom),   27829, pct(27829));
        chk("p03_sigmoid", int'(sigmoid), 574,   2);

        theta = '0;
        step(20);
        chk("z_cosh",    int'(cosh),    15967, pct(15967));
        chk("z_sinh",    int'(sinh),    0,     pct(0));
        chk("z_exp",     int'(exp),     15967, pct(15967));
        chk("z_denom",   int'(denom),   31967, pct(31967));
        chk("z_sigmoid", int'(sigmoid), 500,   2);

        theta = TH_M04;
        step(20);
        chk("m04_cosh",    int'(cosh),    17262, pct(17262));
        chk("m04_sinh",    int'(sinh),    -6559, pct(-6559));
        chk("m04_exp",     int'(exp),     10703, pct(10703));
        chk("m04_denom",   int'(denom),   39820, pct(39820));
        chk("m04_sigmoid", int'(sigmoid), 401,   2);

        theta = TH_P07;
        step(20);
        chk("p07_exp",     int'(exp),     32154, pct(32154));
        chk("p07_denom",   int'(denom),   23929, pct(23929));
        chk("p07_sigmoid", int'(sigmoid), 668,   2);

        // Back-to-back stream: three samples on consecutive clocks.
        theta = TH_P01;
        step(1);
        theta = TH_M07;
        step(1);
        theta = TH_P549;
        step(17);
        chk("strm_pre_sigmoid", int'(sigmoid), 668, 2);
        step(1);
        chk("strm0_sigmoid", int'(sigmoid), 525,   2);
        chk("strm0_exp",     int'(exp),     17646, pct(17646));
        step(1);
        chk("strm1_sigmoid", int'(sigmoid), 331,   2);
        chk("strm1_exp",     int'(exp),     7929,  pct(7929));
        step(1);
        chk("strm2_sigmoid", int'(sigmoid), 634,   2);
        chk("strm2_exp",     int'(exp),     27647, pct(27647));

        // Reset while a stream is in flight.
        theta = TH_P01;
        step(1);
        theta = TH_M07;
        step(1);
        theta = TH_P549;
        step(3);
        rst_n = 1'b0;
        step(1);
        chk_all_zero("midrst");

        rst_n = 1'b1;
        theta = TH_P03;
        for (int i = 1; i <= 19; i++) begin
            step(1);
            chk("flush_cosh", int'(cosh), 0, 0);
        end
        chk("flush_denom",   int'(denom),   16000, 0);
        chk("flush_sigmoid", int'(sigmoid), 1000,  0);
        step(1);
        chk("post_rst_cosh",    int'(cosh),    16691, pct(16691));
        chk("post_rst_sigmoid", int'(sigmoid), 574,   2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
